// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Program-memory fetch handshake between the fetch unit and instruction memory.
//   ImemReq  : fetch request, held until acknowledged
//   ImemAddr : fetch address (the current program counter)
//   ImemAck  : memory acknowledge; ImemData is valid in the same cycle
//   ImemData : fetched instruction word
// The master modport is the fetch unit; the slave modport is the memory.
interface fetch_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) ();

  logic                   ImemReq;
  logic [PC_WIDTH-1:0]    ImemAddr;
  logic                   ImemAck;
  logic [INSTR_WIDTH-1:0] ImemData;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemAck,
    input  ImemData
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemAck,
    output ImemData
  );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
// Program counter and instruction fetch stage ahead of the control decoder.
// Fetches one instruction word per instruction over a req/ack handshake,
// holds it in the instruction register while it executes, then updates the
// PC from the decoder's next-PC select and the ALU jump result.
// Ports:
//   Clock      : system clock, rising edge
//   Reset      : asynchronous, active-high reset
//   PcSel      : next-PC select (2'b00 inc, 2'b01 wait, 2'b10 jump, 2'b11 = inc)
//   JmpTarget  : ALU result, jump destination (low PC_WIDTH bits) on jump
//   imem       : program-memory handshake (master side)
//   Instr      : instruction register
//   InstrValid : Instr is executing this cycle
//   Pc         : current program counter
module fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [1:0]             PcSel,
  input  logic [DATA_WIDTH-1:0]  JmpTarget,
  fetch_unit_if.master           imem,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic                   InstrValid,
  output logic [PC_WIDTH-1:0]    Pc
);

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_WAIT = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   req_q, req_d;
  logic                   valid_q, valid_d;

  // Next-state, next-PC and registered-output computation for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = req_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        // Only reachable through reset; start fetching on the first edge.
        state_d = S_FETCH;
        req_d   = 1'b1;
        valid_d = 1'b0;
      end
      S_FETCH: begin
        if (imem.ImemAck) begin
          instr_d = imem.ImemData;
          state_d = S_EXEC;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end else begin
          req_d   = 1'b1;
          valid_d = 1'b0;
        end
      end
      S_EXEC: begin
        case (PcSel)
          PC_WAIT: begin
            // Hold Pc and Instr; control re-evaluates its condition each cycle.
            req_d   = 1'b0;
            valid_d = 1'b1;
          end
          PC_JMP: begin
            // A jump to the current Pc is a normal refetch, not a wait.
            pc_d    = JmpTarget[PC_WIDTH-1:0];
            state_d = S_FETCH;
            req_d   = 1'b1;
            valid_d = 1'b0;
          end
          default: begin
            // PC_INC and the unused encoding both advance, wrapping at the top.
            pc_d    = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
            state_d = S_FETCH;
            req_d   = 1'b1;
            valid_d = 1'b0;
          end
        endcase
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by Reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= {PC_WIDTH{1'b0}};
      instr_q <= {INSTR_WIDTH{1'b0}};
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign imem.ImemReq  = req_q;
  assign imem.ImemAddr = pc_q;
  assign Instr         = instr_q;
  assign InstrValid    = valid_q;
  assign Pc            = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit: drives the memory side of the handshake and
// the next-PC select, and checks address, request, instruction register and
// valid against hand-computed expectations.
module tb_fetch_unit;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_WAIT = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_ALT  = 2'b11;

  logic        Clock;
  logic        Reset;
  logic [1:0]  PcSel;
  logic [7:0]  JmpTarget;
  logic [15:0] Instr;
  logic        InstrValid;
  logic [7:0]  Pc;

  int tests_run;
  int tests_failed;

  fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) imem ();

  fetch_unit #(
    .PC_WIDTH(8),
    .INSTR_WIDTH(16),
    .DATA_WIDTH(8)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .PcSel(PcSel),
    .JmpTarget(JmpTarget),
    .imem(imem),
    .Instr(Instr),
    .InstrValid(InstrValid),
    .Pc(Pc)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered at a falling edge with the DUT in FETCH at addr; ack after lat cycles.
  task automatic fetch(input string tag, input logic [7:0] addr, input int lat,
                       input logic [15:0] word);
    logic [15:0] old_instr;
    old_instr = Instr;
    for (int i = 0; i < lat; i++) begin
      check({tag, " req"}, 32'(imem.ImemReq), 32'd1);
      check({tag, " addr"}, 32'(imem.ImemAddr), 32'(addr));
      check({tag, " valid"}, 32'(InstrValid), 32'd0);
      check({tag, " instr held"}, 32'(Instr), 32'(old_instr));
      imem.ImemAck  = 1'b0;
      imem.ImemData = ~word;
      @(negedge Clock);
    end
    check({tag, " req"}, 32'(imem.ImemReq), 32'd1);
    check({tag, " addr"}, 32'(imem.ImemAddr), 32'(addr));
    check({tag, " valid"}, 32'(InstrValid), 32'd0);
    imem.ImemAck  = 1'b1;
    imem.ImemData = word;
    @(negedge Clock);
    imem.ImemAck  = 1'b0;
    check({tag, " exec valid"}, 32'(InstrValid), 32'd1);
    check({tag, " exec req"}, 32'(imem.ImemReq), 32'd0);
    check({tag, " exec instr"}, 32'(Instr), 32'(word));
    check({tag, " exec pc"}, 32'(Pc), 32'(addr));
  endtask

  // Entered at a falling edge in EXEC; waits then applies sel, optional spurious acks.
  task automatic exec(input string tag, input logic [1:0] sel, input logic [7:0] tgt,
                      input int waits, input logic [7:0] addr, input logic [15:0] word,
                      input logic [7:0] next_addr, input logic spur);
    for (int w = 0; w < waits; w++) begin
      PcSel         = PC_WAIT;
      imem.ImemAck  = spur;
      imem.ImemData = 16'hBAD0 ^ 16'(w);
      @(negedge Clock);
      check({tag, " wait valid"}, 32'(InstrValid), 32'd1);
      check({tag, " wait instr"}, 32'(Instr), 32'(word));
      check({tag, " wait pc"}, 32'(Pc), 32'(addr));
      check({tag, " wait req"}, 32'(imem.ImemReq), 32'd0);
    end
    PcSel         = sel;
    JmpTarget     = tgt;
    imem.ImemAck  = spur;
    imem.ImemData = 16'hF00D;
    @(negedge Clock);
    imem.ImemAck = 1'b0;
    PcSel        = PC_INC;
    check({tag, " next req"}, 32'(imem.ImemReq), 32'd1);
    check({tag, " next addr"}, 32'(imem.ImemAddr), 32'(next_addr));
    check({tag, " next valid"}, 32'(InstrValid), 32'd0);
    check({tag, " instr kept"}, 32'(Instr), 32'(word));
  endtask

  initial begin
    logic [7:0]  mpc;
    logic [7:0]  nxt;
    logic [7:0]  tgt;
    logic [1:0]  sel;
    logic [15:0] word;
    int          r;

    tests_run     = 0;
    tests_failed  = 0;
    Reset         = 1'b1;
    PcSel         = PC_INC;
    JmpTarget     = 8'h00;
    imem.ImemAck  = 1'b0;
    imem.ImemData = 16'h0000;

    @(negedge Clock);
    @(negedge Clock);
    check("rst pc", 32'(Pc), 32'd0);
    check("rst instr", 32'(Instr), 32'd0);
    check("rst valid", 32'(InstrValid), 32'd0);
    check("rst req", 32'(imem.ImemReq), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    // Sequential words A, B, C at 0, 1, 2 with same-cycle ack.
    fetch("A", 8'h00, 0, 16'hA00A);
    exec("A", PC_INC, 8'h00, 0, 8'h00, 16'hA00A, 8'h01, 1'b0);
    fetch("B", 8'h01, 0, 16'hB00B);
    exec("B", PC_INC, 8'h00, 0, 8'h01, 16'hB00B, 8'h02, 1'b0);
    fetch("C", 8'h02, 0, 16'hC00C);
    exec("C", PC_INC, 8'h00, 0, 8'h02, 16'hC00C, 8'h03, 1'b0);
    fetch("p3", 8'h03, 0, 16'h0003);
    exec("p3", PC_INC, 8'h00, 0, 8'h03, 16'h0003, 8'h04, 1'b0);

    // Jump to 0x3C from Pc=4, then jump back to 5.
    fetch("j4", 8'h04, 0, 16'h0004);
    exec("j4", PC_JMP, 8'h3C, 0, 8'h04, 16'h0004, 8'h3C, 1'b0);
    fetch("j3c", 8'h3C, 0, 16'h003C);
    exec("j3c", PC_JMP, 8'h05, 0, 8'h3C, 16'h003C, 8'h05, 1'b0);

    // Ack delayed three cycles at Pc=5.
    fetch("lat5", 8'h05, 3, 16'h5555);
    exec("lat5", PC_JMP, 8'h09, 0, 8'h05, 16'h5555, 8'h09, 1'b0);

    // Ten wait cycles at Pc=9, then increment to 10.
    fetch("w9", 8'h09, 0, 16'h9999);
    exec("w9", PC_INC, 8'h00, 10, 8'h09, 16'h9999, 8'h0A, 1'b0);

    // Wrap from 0xFF to 0x00, then a self-loop jump back to 0.
    fetch("pa", 8'h0A, 0, 16'h000A);
    exec("pa", PC_JMP, 8'hFF, 0, 8'h0A, 16'h000A, 8'hFF, 1'b0);
    fetch("ff", 8'hFF, 1, 16'hFFFF);
    exec("ff", PC_INC, 8'h00, 0, 8'hFF, 16'hFFFF, 8'h00, 1'b0);
    fetch("self", 8'h00, 0, 16'h1234);
    exec("self", PC_JMP, 8'h00, 0, 8'h00, 16'h1234, 8'h00, 1'b0);

    // Spurious acks throughout EXEC, including the wait cycles.
    fetch("spur", 8'h00, 2, 16'h5A5A);
    exec("spur", PC_ALT, 8'h77, 3, 8'h00, 16'h5A5A, 8'h01, 1'b1);

    // Reset in the middle of a fetch with ack high.
    imem.ImemAck  = 1'b1;
    imem.ImemData = 16'hDEAD;
    Reset         = 1'b1;
    #1;
    check("midrst pc", 32'(Pc), 32'd0);
    check("midrst instr", 32'(Instr), 32'd0);
    check("midrst req", 32'(imem.ImemReq), 32'd0);
    check("midrst valid", 32'(InstrValid), 32'd0);
    @(negedge Clock);
    check("rsthold instr", 32'(Instr), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    imem.ImemAck = 1'b0;
    check("idle ack instr", 32'(Instr), 32'd0);
    check("idle ack req", 32'(imem.ImemReq), 32'd1);
    check("idle ack addr", 32'(imem.ImemAddr), 32'd0);
    check("idle ack valid", 32'(InstrValid), 32'd0);

    // Random latency and next-PC choices against a simple PC model.
    mpc = 8'h00;
    for (int k = 0; k < 12; k++) begin
      word = 16'($urandom);
      fetch("rnd", mpc, int'($urandom_range(0, 7)), word);
      r   = int'($urandom_range(0, 3));
      tgt = 8'($urandom_range(0, 255));
      if (r == 2) begin
        sel = PC_JMP;
        nxt = tgt;
      end else if (r == 3) begin
        sel = PC_ALT;
        nxt = mpc + 8'd1;
      end else begin
        sel = PC_INC;
        nxt = mpc + 8'd1;
      end
      exec("rnd", sel, tgt, int'($urandom_range(0, 2)), mpc, word, nxt, 1'b1);
      mpc = nxt;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
